key_debouncer: RTL

KEY_DEBOUNCER -- requirements
Module: key_debouncer

---
 rtl/key_debouncer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/key_debouncer.sv
// key_debouncer: strobe-sampled key debouncer with registered press/release/long-press events.
// Long-press detection is built only when KEY_DEBOUNCER_LONG_PRESS_EN is defined.
module key_debouncer #(
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned LONG_TICKS   = 250
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Strobe_i,
  input  logic Key_i,
  output logic Pressed_o,
  output logic PressEvent_o,
  output logic ReleaseEvent_o,
  output logic LongEvent_o
);

  localparam int unsigned SW = (STABLE_TICKS < 2) ? 1 : $clog2(STABLE_TICKS);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);

  if (STABLE_TICKS < 2 || LONG_TICKS <= STABLE_TICKS) begin : g_param_check
    $fatal(1, "key_debouncer: need STABLE_TICKS >= 2 and LONG_TICKS > STABLE_TICKS");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t        state, state_next;
  logic          sync1, sync2, key_active;
  logic [SW-1:0] stable_cnt, stable_cnt_next;
  logic          pressed_next, press_ev_next, release_ev_next;

`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LONG_TICKS + 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_TICKS - 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_TICKS);

  logic [LW-1:0] long_cnt, long_cnt_next;
  logic          long_done, long_done_next, long_ev_next;
`endif

  // Synchronizer resets to 1 so a freshly reset key reads as released.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= Key_i;
      sync2 <= sync1;
    end
  end

  assign key_active = ~sync2;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state          <= IDLE;
      stable_cnt     <= '0;
      Pressed_o      <= 1'b0;
      PressEvent_o   <= 1'b0;
      ReleaseEvent_o <= 1'b0;
    end else begin
      state          <= state_next;
      stable_cnt     <= stable_cnt_next;
      Pressed_o      <= pressed_next;
      PressEvent_o   <= press_ev_next;
      ReleaseEvent_o <= release_ev_next;
    end
  end

`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      long_cnt    <= '0;
      long_done   <= 1'b0;
      LongEvent_o <= 1'b0;
    end else begin
      long_cnt    <= long_cnt_next;
      long_done   <= long_done_next;
      LongEvent_o <= long_ev_next;
    end
  end
`else
  assign LongEvent_o = 1'b0;
`endif

  always_comb begin
    state_next      = state;
    stable_cnt_next = stable_cnt;
    press_ev_next   = 1'b0;
    release_ev_next = 1'b0;
`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
    long_cnt_next   = long_cnt;
    long_done_next  = long_done;
    long_ev_next    = 1'b0;
`endif
    if (Strobe_i) begin
      case (state)
        IDLE: begin
          if (key_active) begin
            state_next      = PRESS_WAIT;
            stable_cnt_next = SW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!key_active) begin
            state_next      = IDLE;
            stable_cnt_next = '0;
          end else if (stable_cnt == STABLE_LAST) begin
            state_next      = PRESSED;
            stable_cnt_next = '0;
            press_ev_next   = 1'b1;
`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
            long_cnt_next   = '0;
            long_done_next  = 1'b0;
`endif
          end else begin
            stable_cnt_next = stable_cnt + SW'(1);
          end
        end
        PRESSED: begin
          if (!key_active) begin
            state_next      = RELEASE_WAIT;
            stable_cnt_next = SW'(1);
          end
`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
          else begin
            if (long_cnt != LONG_MAX) long_cnt_next = long_cnt + LW'(1);
            if (long_cnt == LONG_LAST && !long_done) begin
              long_ev_next   = 1'b1;
              long_done_next = 1'b1;
            end
          end
`endif
        end
        RELEASE_WAIT: begin
          // Bounce back to PRESSED keeps the long-press count running.
          if (key_active) begin
            state_next      = PRESSED;
            stable_cnt_next = '0;
          end else if (stable_cnt == STABLE_LAST) begin
            state_next      = IDLE;
            stable_cnt_next = '0;
            release_ev_next = 1'b1;
          end else begin
            stable_cnt_next = stable_cnt + SW'(1);
          end
        end
        default: begin
          state_next      = IDLE;
          stable_cnt_next = '0;
        end
      endcase
    end
  end

  assign pressed_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);

endmodule
